// File: rtl/scope_capture_buffer_if.sv
// Byte stream from the capture buffer to the UART transmitter.
// A byte transfers on a cycle where tx_valid and tx_ready are both high; once
// tx_valid rises, tx_data and tx_valid hold until that transfer happens.
interface scope_capture_buffer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/scope_capture_buffer.sv
// Armed circular sample capture with level-crossing trigger; after the post-trigger
// window fills, streams header + DEPTH samples in time order to the UART.
module scope_capture_buffer #(
  parameter int               DATA_W  = 8,
  parameter int               DEPTH   = 256,
  parameter int               ADDR_W  = 8,
  parameter int               PRETRIG = 32,
  parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic                arm,
  input  logic [DATA_W-1:0]   trig_level,
  input  logic                trig_rising,
  input  logic                force_trig,
  scope_capture_buffer_if.master tx,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(DEPTH - PRETRIG);
  localparam logic [ADDR_W:0]   LAST_BYTE = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic                rising_q, rising_d;
  logic                force_q, force_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_q, done_d;
  logic                rd_pend_q, rd_pend_d;
  logic                mem_we;
  logic                enter_dump;
  logic                hit;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    byte_cnt_d = byte_cnt_q;
    prev_d     = prev_q;
    prev_ok_d  = prev_ok_q;
    level_d    = level_q;
    rising_d   = rising_q;
    force_d    = force_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    rd_pend_d  = 1'b0;
    mem_we     = 1'b0;
    enter_dump = 1'b0;
    hit        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_PRE;
          level_d    = trig_level;
          rising_d   = trig_rising;
          wr_ptr_d   = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          prev_ok_d  = 1'b0;
          force_d    = 1'b0;
        end
      end
      S_PRE: begin
        if (sample_valid) begin
          mem_we    = 1'b1;
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (force_trig) force_d = 1'b1;
        if (sample_valid) begin
          mem_we = 1'b1;
          if (rising_q) hit = (prev_q < level_q) && (sample_in >= level_q);
          else          hit = (prev_q > level_q) && (sample_in <= level_q);
          hit = prev_ok_q && (hit || force_trig || force_q);
          if (hit) begin
            force_d    = 1'b0;
            post_cnt_d = (ADDR_W+1)'(1);
            // Oldest kept sample sits PRETRIG slots behind the trigger write.
            rd_ptr_d   = wr_ptr_q - PRE_OFS;
            if (POST_LAST == (ADDR_W+1)'(1)) enter_dump = 1'b1;
            else                              state_d    = S_POST;
          end
        end
      end
      S_POST: begin
        if (sample_valid) begin
          mem_we     = 1'b1;
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == POST_LAST) enter_dump = 1'b1;
        end
      end
      S_DUMP: begin
        // rd_data_q holds the byte fetched on the cycle of the last handshake.
        if (rd_pend_q) begin
          tx_data_d  = rd_data_q;
          tx_valid_d = 1'b1;
        end
        if (tx_valid_q && tx.tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_cnt_q == LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_pend_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_we) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = sample_in;
      prev_ok_d = 1'b1;
    end
    if (enter_dump) begin
      state_d    = S_DUMP;
      byte_cnt_d = '0;
      tx_data_d  = HEADER;
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      byte_cnt_q <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      level_q    <= '0;
      rising_q   <= 1'b0;
      force_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
      level_q    <= level_d;
      rising_q   <= rising_d;
      force_q    <= force_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= sample_in;
    rd_data_q <= mem[rd_ptr_q];
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer (DEPTH=16, PRETRIG=4): stimulus pushes
// expected frame bytes, a negedge monitor pops and compares every accepted byte.
module tb_scope_capture_buffer;
  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int ADDR_W  = 4;

  typedef logic [7:0] frame_t [16];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_rising = 1'b0;
  logic       force_trig = 1'b0;
  logic       busy, done;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  scope_capture_buffer_if #(.DATA_W(8)) tx_if();

  scope_capture_buffer #(
    .DATA_W(8), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
    .force_trig(force_trig),
    .tx(tx_if),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte", tx_if.tx_data);
        end else begin
          check("frame_byte", {24'h0, tx_if.tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_txvalid", {31'h0, tx_if.tx_valid}, 32'h0);
        check("done_busy", {31'h0, busy}, 32'h0);
      end
    end
  end

  task automatic push_frame(input frame_t f);
    exp_q.push_back(8'hA5);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  task automatic put(input logic [7:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic rise);
    trig_level  = lvl;
    trig_rising = rise;
    arm         = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    @(posedge clk); #1;
    force_trig = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int base;
    int cyc;
    base = done_cnt;
    cyc  = 0;
    while (!tx_if.tx_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("dump_valid", {31'h0, tx_if.tx_valid}, 32'h1);
    if (bp) begin
      repeat (10) begin
        @(negedge clk);
        check("bp_valid", {31'h0, tx_if.tx_valid}, 32'h1);
        check("bp_data", {24'h0, tx_if.tx_data}, 32'hA5);
      end
    end
    cyc = 0;
    while (done_cnt == base && cyc < 400) begin
      @(posedge clk); #1;
      tx_if.tx_ready = bp ? ~tx_if.tx_ready : 1'b1;
      cyc++;
    end
    repeat (4) @(negedge clk);
    check("done_once", done_cnt - base, 32'd1);
    check("frame_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txvalid", {31'h0, tx_if.tx_valid}, 32'h0);
    check("rst_txdata", {24'h0, tx_if.tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Rising trigger on a ramp; force_trig outside WAIT_TRIG must not latch.
    tx_if.tx_ready = 1'b0;
    pulse_force();
    do_arm(8'h80, 1'b1);
    check("arm_busy", {31'h0, busy}, 32'h1);
    push_frame('{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0,
                 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h00, 8'h10, 8'h20, 8'h30});
    put(8'h00);
    pulse_force();
    put(8'h10); put(8'h20); put(8'h30);
    check("pre_to_wait", {29'h0, dbg_state}, 32'd2);
    for (int i = 4; i < 16; i++) put(8'(i * 16));
    for (int i = 0; i < 4; i++) put(8'(i * 16));
    check("post_to_dump", {29'h0, dbg_state}, 32'd4);
    fork
      drain(1'b0);
      begin
        repeat (3) @(posedge clk); #1;
        put(8'hEE); put(8'hEE); put(8'hEE);
        do_arm(8'h10, 1'b0);
      end
    join

    // Falling trigger at equality, arm while busy, then backpressure.
    tx_if.tx_ready = 1'b0;
    do_arm(8'h40, 1'b0);
    push_frame('{8'h30, 8'h35, 8'h90, 8'h60, 8'h40, 8'h41, 8'h42, 8'h43,
                 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B});
    put(8'h10); put(8'h20); put(8'h30); put(8'h35);
    put(8'h90);
    do_arm(8'h00, 1'b1);
    put(8'h60);
    check("fall_no_trig_yet", {29'h0, dbg_state}, 32'd2);
    put(8'h40);
    check("fall_trig", {29'h0, dbg_state}, 32'd3);
    for (int v = 8'h41; v <= 8'h4B; v++) put(8'(v));
    drain(1'b1);

    // Wrap: 34 non-triggering samples, then a latched force_trig.
    tx_if.tx_ready = 1'b0;
    do_arm(8'hFF, 1'b1);
    push_frame('{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D});
    for (int i = 0; i < 34; i++) put(8'(i));
    check("wrap_wait", {29'h0, dbg_state}, 32'd2);
    pulse_force();
    check("force_latched_wait", {29'h0, dbg_state}, 32'd2);
    put(8'h22);
    check("force_trig", {29'h0, dbg_state}, 32'd3);
    for (int v = 8'h23; v <= 8'h2D; v++) put(8'(v));
    drain(1'b0);

    // Reset in the middle of a dump, then no output without a new arm.
    tx_if.tx_ready = 1'b0;
    do_arm(8'h00, 1'b0);
    repeat (5) put(8'h05);
    put(8'h00);
    repeat (11) put(8'h07);
    @(negedge clk);
    check("mid_dump_valid", {31'h0, tx_if.tx_valid}, 32'h1);
    check("mid_dump_state", {29'h0, dbg_state}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("abort_txvalid", {31'h0, tx_if.tx_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_state", {29'h0, dbg_state}, 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    tx_if.tx_ready = 1'b1;
    repeat (4) put(8'h99);
    repeat (30) @(negedge clk);
    check("post_rst_txvalid", {31'h0, tx_if.tx_valid}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    check("done_total", done_cnt, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
